// File: rtl/sipo_framer_if.sv
// Serial-in / parallel-out framer bus.
// Serial strobe side plus the parallel valid/ready word side.
interface sipo_framer_if #(
    parameter int WIDTH = 4
);
    logic             si;
    logic             si_en;
    logic             sof;
    logic [WIDTH-1:0] po;
    logic             po_valid;
    logic             po_ready;
    logic             overrun;
    logic             clr_ovr;
    logic             sync_err;

    modport master (
        output si, si_en, sof, po_ready, clr_ovr,
        input  po, po_valid, overrun, sync_err
    );

    modport slave (
        input  si, si_en, sof, po_ready, clr_ovr,
        output po, po_valid, overrun, sync_err
    );
endinterface

// File: rtl/sipo_framer.sv
// MSB-first serial deserializer with sof framing, a one-word output
// register, sticky overrun and a sync-error pulse on mid-word restarts.
module sipo_framer #(
    parameter int WIDTH = 4
) (
    input logic           clk,
    input logic           rst,
    sipo_framer_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] nxt;
    logic             last;
    logic             take;
    logic             drop;

    assign nxt  = {sreg[WIDTH-2:0], bus.si};
    // sof on the final bit is a restart, never a completion
    assign last = (state == SHIFT) && bus.si_en && !bus.sof &&
                  (cnt == CW'(WIDTH - 1));
    assign take = last && (!bus.po_valid || bus.po_ready);
    assign drop = last && bus.po_valid && !bus.po_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            sreg         <= '0;
            bus.po       <= '0;
            bus.po_valid <= 1'b0;
            bus.overrun  <= 1'b0;
            bus.sync_err <= 1'b0;
        end else begin
            bus.sync_err <= 1'b0;
            if (bus.si_en) begin
                unique case (state)
                    IDLE: begin
                        if (bus.sof) begin
                            sreg  <= nxt;
                            cnt   <= CW'(1);
                            state <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        sreg <= nxt;
                        if (bus.sof) begin
                            cnt          <= CW'(1);
                            bus.sync_err <= 1'b1;
                        end else if (last) begin
                            cnt   <= '0;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end

            if (take) begin
                bus.po       <= nxt;
                bus.po_valid <= 1'b1;
            end else if (bus.po_valid && bus.po_ready) begin
                bus.po_valid <= 1'b0;
            end

            // a drop in the same cycle as a clear keeps the flag set
            if (drop) begin
                bus.overrun <= 1'b1;
            end else if (bus.clr_ovr) begin
                bus.overrun <= 1'b0;
            end
        end
    end
endmodule
